adc_init_seq: RTL

ADC_INIT_SEQ -- requirements
Module: adc_init_seq

---
 rtl/adc_init_seq_pkg.sv | 48 ++++
 rtl/adc_init_seq_if.sv | 9 +
 rtl/adc_init_seq_rom.sv | 9 +
 rtl/adc_init_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/adc_init_seq_pkg.sv
// Shared types and the ADC command table for the initialisation sequencer.
// Macro ADC_TEST_PATTERN_EN appends the ramp test-pattern word to the table.
package adc_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PWR_WAIT = 3'd1,
        ST_LOAD     = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5
    } init_state_t;

`ifdef ADC_TEST_PATTERN_EN
    localparam int N_WORDS = 9;
`else
    localparam int N_WORDS = 8;
`endif
    localparam int IDX_W = $clog2(N_WORDS);

    localparam logic [15:0] CMD_SOFT_RESET = 16'h0800;
    localparam logic [15:0] CMD_CHIP_CFG   = 16'h0100;
    localparam logic [15:0] CMD_CLK_DIV    = 16'h0B00;
    localparam logic [15:0] CMD_OUT_MODE   = 16'h1401;
    localparam logic [15:0] CMD_OUT_ADJ    = 16'h1500;
    localparam logic [15:0] CMD_OUT_PHASE  = 16'h1600;
    localparam logic [15:0] CMD_VREF       = 16'h1800;
    localparam logic [15:0] CMD_XFER       = 16'hFF01;
    localparam logic [15:0] CMD_TEST_RAMP  = 16'h0D04;

    function automatic logic [15:0] cmd_word(input logic [IDX_W-1:0] idx);
        case (32'(idx))
            0:       return CMD_SOFT_RESET;
            1:       return CMD_CHIP_CFG;
            2:       return CMD_CLK_DIV;
            3:       return CMD_OUT_MODE;
            4:       return CMD_OUT_ADJ;
            5:       return CMD_OUT_PHASE;
            6:       return CMD_VREF;
            7:       return CMD_XFER;
`ifdef ADC_TEST_PATTERN_EN
            8:       return CMD_TEST_RAMP;
`endif
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/adc_init_seq_if.sv
// Three-wire ADC serial configuration bus driven by the init sequencer.
interface adc_init_seq_if;
    logic ADC_CSB;
    logic ADC_SCLK;
    logic ADC_SDATA;

    modport master (output ADC_CSB, ADC_SCLK, ADC_SDATA);
    modport slave  (input  ADC_CSB, ADC_SCLK, ADC_SDATA);
endinterface

// File: rtl/adc_init_seq_rom.sv
// Combinational index-to-command-word lookup into the package table.
module adc_init_rom
    import adc_init_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [15:0]      word
);
    assign word = cmd_word(idx);
endmodule

// File: rtl/adc_init_seq.sv
// ADC initialisation sequencer: waits PWR_DLY cycles after release, then shifts the
// command table out MSB first on CSB/SCLK/SDATA. ADC_TEST_PATTERN_EN adds a ninth word.
module adc_init_seq
    import adc_init_pkg::*;
#(
    parameter logic [15:0] PWR_DLY  = 16'd1000,
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           ADC_INIT_RST,
    input  logic           ADC_REINIT,
    output logic           ADC_RDY,
    output logic [2:0]     INIT_STATE,
    adc_init_seq_if.master adc
);
    localparam logic [7:0]       DIV_LAST = 8'(SCLK_DIV - 1);
    localparam logic [8:0]       GAP_LAST = 9'(2 * SCLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);
    localparam logic [15:0]      DLY_LAST = PWR_DLY - 16'd1;

    init_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      dly_q, dly_d;
    logic [7:0]       div_q, div_d;
    logic [3:0]       bit_q, bit_d;
    logic [8:0]       gap_q, gap_d;
    logic [15:0]      shreg_q, shreg_d, rom_word;
    logic             csb_q, csb_d;
    logic             sclk_q, sclk_d;
    logic             sdata_q, sdata_d;
    logic             rdy_q, rdy_d;
    logic             sclk_tick;

    // Addressed with the next index so the word is ready the cycle Load is entered.
    adc_init_rom u_rom (
        .idx  (idx_d),
        .word (rom_word)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dly_d     = dly_q;
        div_d     = '0;
        bit_d     = bit_q;
        gap_d     = '0;
        sclk_tick = 1'b0;
        if (ADC_INIT_RST) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            dly_d   = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_PWR_WAIT;
                    dly_d   = '0;
                end
                ST_PWR_WAIT: begin
                    if (dly_q == DLY_LAST) state_d = ST_LOAD;
                    else                   dly_d   = dly_q + 16'd1;
                end
                ST_LOAD: begin
                    state_d = ST_SHIFT;
                    bit_d   = '0;
                end
                ST_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        sclk_tick = 1'b1;
                        if (sclk_q) begin
                            if (bit_q == 4'd15) state_d = ST_GAP;
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = ST_LOAD;
                        end
                    end else begin
                        gap_d = gap_q + 9'd1;
                    end
                end
                ST_DONE: begin
                    if (ADC_REINIT) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    dly_d   = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    // Pin values are decoded from the state being entered, so each output flop
    // already holds the right level in the first cycle of that state.
    always_comb begin
        csb_d   = 1'b1;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        rdy_d   = 1'b0;
        shreg_d = shreg_q;
        case (state_d)
            ST_LOAD: begin
                csb_d   = 1'b0;
                shreg_d = rom_word;
                sdata_d = rom_word[15];
            end
            ST_SHIFT: begin
                csb_d  = 1'b0;
                sclk_d = sclk_q ^ sclk_tick;
                if (sclk_tick && sclk_q) begin
                    shreg_d = {shreg_q[14:0], 1'b0};
                    sdata_d = shreg_q[14];
                end else begin
                    sdata_d = shreg_q[15];
                end
            end
            ST_DONE: rdy_d = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dly_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shreg_q <= '0;
            csb_q   <= 1'b1;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            csb_q   <= csb_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            rdy_q   <= rdy_d;
        end
    end

    assign ADC_RDY       = rdy_q;
    assign INIT_STATE    = state_q;
    assign adc.ADC_CSB   = csb_q;
    assign adc.ADC_SCLK  = sclk_q;
    assign adc.ADC_SDATA = sdata_q;

endmodule
